// File: rtl/mfda_ctrl_pkg.sv
// Shared types and constants for the mix-cycle sequencer: state encoding,
// fail-safe valve level and the peristaltic pump drive pattern.
package mfda_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_FILL         = 4'd1,
    ST_SETTLE1      = 4'd2,
    ST_MIX          = 4'd3,
    ST_INCUBATE     = 4'd4,
    ST_FLUSH        = 4'd5,
    ST_SETTLE2      = 4'd6,
    ST_DONE         = 4'd7,
    ST_ABORT_SETTLE = 4'd8,
    ST_ABORT_DONE   = 4'd9
  } state_t;

  localparam logic VALVE_CLOSED = 1'b1;

  localparam int unsigned PUMP_STEPS = 6;

  // Step 0 in the low 3 bits; each entry is bit2..bit0 of pump_valves.
  localparam logic [17:0] PUMP_PATTERN = {3'b010, 3'b011, 3'b001,
                                          3'b101, 3'b100, 3'b110};

  typedef struct packed {
    logic       in_a;
    logic       in_b;
    logic       out;
    logic [2:0] pump;
  } valve_t;

  function automatic valve_t valve_drive(input state_t st, input logic [2:0] step);
    valve_t v;
    v.in_a = VALVE_CLOSED;
    v.in_b = VALVE_CLOSED;
    v.out  = VALVE_CLOSED;
    v.pump = {3{VALVE_CLOSED}};
    case (st)
      ST_FILL: begin
        v.in_a = ~VALVE_CLOSED;
        v.in_b = ~VALVE_CLOSED;
        v.pump = {3{~VALVE_CLOSED}};
      end
      ST_MIX: v.pump = PUMP_PATTERN[3*int'(step) +: 3];
      ST_FLUSH: begin
        v.in_a = ~VALVE_CLOSED;
        v.out  = ~VALVE_CLOSED;
        v.pump = {3{~VALVE_CLOSED}};
      end
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mix_cycle_ctrl_phase_timer.sv
// Shared phase down-counter: loads length-1 on phase entry, expires at zero.
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/mix_cycle_ctrl.sv
// Mix-cycle sequencer: fill, settle, peristaltic mix, incubate, flush, settle,
// with abort handling. All outputs are registered from the next-state values.
module mix_cycle_ctrl
  import mfda_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_LEN = 4,
  parameter int unsigned ROUND_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_fill_len,
  input  logic [CNT_W-1:0]   cfg_step_len,
  input  logic [ROUND_W-1:0] cfg_rounds,
  input  logic [CNT_W-1:0]   cfg_incubate_len,
  input  logic [CNT_W-1:0]   cfg_flush_len,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               valve_in_a,
  output logic               valve_in_b,
  output logic               valve_out,
  output logic [2:0]         pump_valves,
  output logic [3:0]         state_o
);

  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_LEN - 1);
  localparam logic [2:0]       LAST_STEP = 3'(PUMP_STEPS - 1);

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  state_t             state, next_state;
  logic [2:0]         step, next_step;
  logic [ROUND_W-1:0] rounds, next_rounds;
  logic [CNT_W-1:0]   lat_step, lat_incubate, lat_flush;
  logic               cfg_latch;
  logic               tmr_load, tmr_expire;
  logic [CNT_W-1:0]   tmr_val;
  valve_t             next_valves;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    next_state  = state;
    next_step   = step;
    next_rounds = rounds;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    cfg_latch   = 1'b0;
    case (state)
      ST_IDLE: if (start && !abort) begin
        next_state  = ST_FILL;
        next_rounds = cfg_rounds;
        cfg_latch   = 1'b1;
        tmr_load    = 1'b1;
        tmr_val     = len_m1(cfg_fill_len);
      end
      ST_FILL: if (tmr_expire) begin
        next_state = ST_SETTLE1;
        tmr_load   = 1'b1;
        tmr_val    = SETTLE_M1;
      end
      ST_SETTLE1: if (tmr_expire) begin
        tmr_load = 1'b1;
        if (rounds == '0) begin
          next_state = ST_INCUBATE;
          tmr_val    = len_m1(lat_incubate);
        end else begin
          next_state = ST_MIX;
          next_step  = '0;
          tmr_val    = len_m1(lat_step);
        end
      end
      // Round count is only decremented after the last pattern step.
      ST_MIX: if (tmr_expire) begin
        tmr_load = 1'b1;
        if (step != LAST_STEP) begin
          next_step = step + 3'd1;
          tmr_val   = len_m1(lat_step);
        end else begin
          next_rounds = rounds - 1'b1;
          next_step   = '0;
          if (next_rounds == '0) begin
            next_state = ST_INCUBATE;
            tmr_val    = len_m1(lat_incubate);
          end else begin
            tmr_val = len_m1(lat_step);
          end
        end
      end
      ST_INCUBATE: if (tmr_expire) begin
        next_state = ST_FLUSH;
        tmr_load   = 1'b1;
        tmr_val    = len_m1(lat_flush);
      end
      ST_FLUSH: if (tmr_expire) begin
        next_state = ST_SETTLE2;
        tmr_load   = 1'b1;
        tmr_val    = SETTLE_M1;
      end
      ST_SETTLE2:      if (tmr_expire) next_state = ST_DONE;
      ST_DONE:         next_state = ST_IDLE;
      ST_ABORT_SETTLE: if (tmr_expire) next_state = ST_ABORT_DONE;
      ST_ABORT_DONE:   next_state = ST_IDLE;
      default:         next_state = ST_IDLE;
    endcase

    if (abort && (state inside {ST_FILL, ST_SETTLE1, ST_MIX, ST_INCUBATE,
                                ST_FLUSH, ST_SETTLE2})) begin
      next_state  = ST_ABORT_SETTLE;
      next_step   = step;
      next_rounds = rounds;
      tmr_load    = 1'b1;
      tmr_val     = SETTLE_M1;
    end

    next_valves = valve_drive(next_state, next_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      step         <= '0;
      rounds       <= '0;
      lat_step     <= '0;
      lat_incubate <= '0;
      lat_flush    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      valve_in_a   <= VALVE_CLOSED;
      valve_in_b   <= VALVE_CLOSED;
      valve_out    <= VALVE_CLOSED;
      pump_valves  <= {3{VALVE_CLOSED}};
    end else begin
      state  <= next_state;
      step   <= next_step;
      rounds <= next_rounds;
      if (cfg_latch) begin
        lat_step     <= cfg_step_len;
        lat_incubate <= cfg_incubate_len;
        lat_flush    <= cfg_flush_len;
      end
      busy        <= !(next_state inside {ST_IDLE, ST_DONE, ST_ABORT_DONE});
      done        <= (next_state == ST_DONE);
      aborted     <= (next_state == ST_ABORT_DONE);
      valve_in_a  <= next_valves.in_a;
      valve_in_b  <= next_valves.in_b;
      valve_out   <= next_valves.out;
      pump_valves <= next_valves.pump;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mix_cycle_ctrl.sv
// Directed, table-driven bench for mix_cycle_ctrl: per-cycle expected traces
// are written out as phase segments for each test record.
module tb_mix_cycle_ctrl;

  localparam int CNT_W      = 16;
  localparam int ROUND_W    = 8;
  localparam int SETTLE_LEN = 4;

  localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_S1 = 4'd2, S_MIX = 4'd3,
                         S_INC = 4'd4, S_FLUSH = 4'd5, S_S2 = 4'd6, S_DONE = 4'd7,
                         S_AS = 4'd8, S_AD = 4'd9;

  logic               clk, rst, start, abort;
  logic [CNT_W-1:0]   cfg_fill_len, cfg_step_len, cfg_incubate_len, cfg_flush_len;
  logic [ROUND_W-1:0] cfg_rounds;
  logic               busy, done, aborted, valve_in_a, valve_in_b, valve_out;
  logic [2:0]         pump_valves;
  logic [3:0]         state_o;

  mix_cycle_ctrl #(.CNT_W(CNT_W), .SETTLE_LEN(SETTLE_LEN), .ROUND_W(ROUND_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_fill_len     (cfg_fill_len),
    .cfg_step_len     (cfg_step_len),
    .cfg_rounds       (cfg_rounds),
    .cfg_incubate_len (cfg_incubate_len),
    .cfg_flush_len    (cfg_flush_len),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .valve_in_a       (valve_in_a),
    .valve_in_b       (valve_in_b),
    .valve_out        (valve_out),
    .pump_valves      (pump_valves),
    .state_o          (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       a;
    logic       b;
    logic       o;
    logic [2:0] pump;
  } obs_t;

  typedef struct {
    string      name;
    logic [15:0] f, p;
    logic [7:0]  r;
    logic [15:0] i, l;
    int          pulse_k, cfg_k, abort_k, rst_k;
  } vec_t;

  vec_t       tests[7];
  obs_t       exp_q[$];
  logic [2:0] pat[6];
  int         n_run, n_fail;

  function automatic obs_t expect_of(input logic [3:0] st, input logic [2:0] pump);
    obs_t e;
    e.st      = st;
    e.busy    = !(st == S_IDLE || st == S_DONE || st == S_AD);
    e.done    = (st == S_DONE);
    e.aborted = (st == S_AD);
    e.a = 1'b1; e.b = 1'b1; e.o = 1'b1; e.pump = 3'b111;
    if (st == S_FILL)  begin e.a = 1'b0; e.b = 1'b0; e.pump = 3'b000; end
    if (st == S_MIX)   e.pump = pump;
    if (st == S_FLUSH) begin e.a = 1'b0; e.o = 1'b0; e.pump = 3'b000; end
    return e;
  endfunction

  task automatic seg(input logic [3:0] st, input int n);
    repeat (n) exp_q.push_back(expect_of(st, 3'b111));
  endtask

  task automatic mix_seg(input int p, input int first, input int last);
    for (int s = first; s <= last; s++)
      repeat (p) exp_q.push_back(expect_of(S_MIX, pat[s]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input obs_t e);
    obs_t act;
    act = {state_o, busy, done, aborted, valve_in_a, valve_in_b, valve_out, pump_valves};
    n_run++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got st=%0d busy=%b done=%b aborted=%b a/b/o=%b%b%b pump=%b, expected st=%0d busy=%b done=%b aborted=%b a/b/o=%b%b%b pump=%b",
               name, k, act.st, act.busy, act.done, act.aborted, act.a, act.b, act.o, act.pump,
               e.st, e.busy, e.done, e.aborted, e.a, e.b, e.o, e.pump);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick();
    rst = 1'b0;
    check("reset", 0, expect_of(S_IDLE, 3'b111));
  endtask

  task automatic build(input int t);
    exp_q.delete();
    case (t)
      0, 3: begin
        seg(S_FILL, 2); seg(S_S1, 4); mix_seg(1, 0, 5); seg(S_INC, 3);
        seg(S_FLUSH, 2); seg(S_S2, 4); seg(S_DONE, 1); seg(S_IDLE, 2);
      end
      1: begin
        seg(S_FILL, 1); seg(S_S1, 4); seg(S_INC, 1); seg(S_FLUSH, 1);
        seg(S_S2, 4); seg(S_DONE, 1); seg(S_IDLE, 2);
      end
      2: begin
        seg(S_FILL, 2); seg(S_S1, 4); mix_seg(1, 0, 3); seg(S_AS, 4);
        seg(S_AD, 1); seg(S_IDLE, 1); seg(S_FILL, 1);
      end
      4: begin
        seg(S_FILL, 2); seg(S_S1, 4); mix_seg(1, 0, 5); seg(S_INC, 3);
        seg(S_FLUSH, 1); seg(S_IDLE, 2);
      end
      5: seg(S_IDLE, 3);
      default: begin
        seg(S_FILL, 1); seg(S_S1, 4); mix_seg(2, 0, 5); mix_seg(2, 0, 5);
        seg(S_INC, 1); seg(S_FLUSH, 1); seg(S_S2, 4); seg(S_DONE, 1); seg(S_IDLE, 2);
      end
    endcase
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_fill_len = '0; cfg_step_len = '0; cfg_rounds = '0;
    cfg_incubate_len = '0; cfg_flush_len = '0;
    pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b101;
    pat[3] = 3'b001; pat[4] = 3'b011; pat[5] = 3'b010;

    //           name          F  P  R  I  L  pulse cfg abort rst
    tests[0] = '{"normal",     2, 1, 1, 3, 2, 0,    0,  0,    0};
    tests[1] = '{"zero_len",   0, 0, 0, 0, 0, 0,    0,  0,    0};
    tests[2] = '{"abort_mix",  2, 1, 1, 3, 2, 17,   0,  11,   0};
    tests[3] = '{"busy_start", 2, 1, 1, 3, 2, 5,    3,  0,    0};
    tests[4] = '{"rst_flush",  2, 1, 1, 3, 2, 0,    0,  0,    17};
    tests[5] = '{"start_abrt", 2, 1, 1, 3, 2, 0,    0,  1,    0};
    tests[6] = '{"two_rounds", 1, 2, 2, 1, 1, 0,    0,  0,    0};

    repeat (2) tick();
    do_reset();

    for (int t = 0; t < 7; t++) begin
      cfg_fill_len     = tests[t].f;
      cfg_step_len     = tests[t].p;
      cfg_rounds       = tests[t].r;
      cfg_incubate_len = tests[t].i;
      cfg_flush_len    = tests[t].l;
      build(t);
      for (int k = 1; k <= exp_q.size(); k++) begin
        start = (k == 1) || (k == tests[t].pulse_k);
        abort = (k == tests[t].abort_k);
        rst   = (k == tests[t].rst_k);
        if (k == tests[t].cfg_k) begin
          cfg_fill_len = 16'd9; cfg_step_len = 16'd7; cfg_rounds = 8'd3;
          cfg_incubate_len = 16'd11; cfg_flush_len = 16'd5;
        end
        tick();
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        check(tests[t].name, k, exp_q[k-1]);
      end
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_cycle_ctrl.md
Name: mix_cycle_ctrl

Overview:
Clocked sequencer that runs one complete mix cycle on the inlet valves, 3-valve peristaltic pump and outlet valve around the diffusion mixer / serpentine chamber.
- Cycle order: fill, settle, peristaltic mix, incubate, flush, settle.
- Each `valve_*` / `pump_valves` output drives the `air_in` control line of one valve instance.
- Per-run timing comes from config ports, which are latched at start.
- Sits between the host/protocol logic and the fluidic netlist.

Parameters:
- CNT_W, 16, width of all phase-length config fields and the internal phase counter.
- SETTLE_LEN, 4, cycles all valves are held closed between fill and mix, after flush, and on abort (must be ≥1).
- ROUND_W, 8, width of `cfg_rounds`.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; sampled every cycle.
- cfg_fill_len  in  CNT_W  fill phase cycles.
- cfg_step_len  in  CNT_W  cycles per pump pattern step.
- cfg_rounds  in  ROUND_W  pump rounds (6 steps each).
- cfg_incubate_len  in  CNT_W  incubate cycles.
- cfg_flush_len  in  CNT_W  flush cycles.
- busy  out  1  high while a cycle is in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- valve_in_a  out  1  inlet A air line (1 = pressurized/closed).
- valve_in_b  out  1  inlet B air line.
- valve_out  out  1  outlet air line.
- pump_valves  out  3  pump air lines, bit0..bit2.
- state_o  out  3  current state encoding (debug).

Behaviour:
- Reset state: IDLE.
  - `busy` = 0, `done` = 0, `aborted` = 0.
  - All valve outputs = 1 (closed, fail-safe).
  - Applies mid-operation with no settle phase.
- All outputs are registered; valve outputs are a pure function of the registered state and step index.
- Start:
  - `start`=1 in IDLE at cycle t: config latched at t; state = FILL at t+1.
  - `start` while busy is ignored.
  - `start` and `abort` together in IDLE: `abort` wins, `start` ignored, stays IDLE, no `aborted` pulse.
- Phase length rule: a length field L gives max(L,1) cycles.
- States and valve drive (in_a, in_b, out, pump):
  - IDLE: 1,1,1,111.
  - FILL: 0,0,1,000 for fill cycles → SETTLE1.
  - SETTLE1: 1,1,1,111 for SETTLE_LEN → MIX, or → INCUBATE if `cfg_rounds`==0.
  - MIX: 1,1,1,pattern[step]. Pattern steps 0..5 = 110,100,101,001,011,010 (bit2..bit0). Each step lasts step cycles. After step 5, rounds decrements; repeat until 0 → INCUBATE.
  - INCUBATE: 1,1,1,111 for incubate cycles → FLUSH.
  - FLUSH: 0,1,0,000 (inlet A carries buffer) for flush cycles → SETTLE2.
  - SETTLE2: 1,1,1,111 for SETTLE_LEN → DONE.
  - DONE: one cycle, all closed, `done`=1 → IDLE.
- `busy`:
  - 1 in every state except IDLE, DONE and ABORT_DONE.
  - Total busy cycles = F+S+6·R·P+I+L+S, with each length after the max(L,1) rule, R=`cfg_rounds`, P=step length.
- Abort:
  - `abort`=1 in any busy state: next cycle ABORT_SETTLE, all valves closed.
  - ABORT_SETTLE lasts SETTLE_LEN cycles, then ABORT_DONE: one cycle, `aborted`=1, no `done` → IDLE.
  - `abort` during ABORT_SETTLE is ignored. `abort` in DONE is ignored; `done` still fires.
- Counters: the phase counter loads length−1 on phase entry and the phase ends when it reads 0. No wrap.
- Round counter: ROUND_W bits, loaded from the latched `cfg_rounds`.
- Config changes while busy have no effect.

Decomposition:
- Package `mfda_ctrl_pkg`:
  - state enum (IDLE, FILL, SETTLE1, MIX, INCUBATE, FLUSH, SETTLE2, DONE, ABORT_SETTLE, ABORT_DONE; 4-bit internal, `state_o` = low 3 bits of encoding is NOT acceptable → `state_o` width is 4).
  - VALVE_CLOSED=1'b1.
  - 6-entry pump pattern constant.
- Correction to Ports: `state_o` width is 4.
- One sub-module `phase_timer`: CNT_W down-counter with load/value inputs and an `expire` output; instantiated once and shared by all phases.

Test Plan:
- Normal run (F=2, step=1, R=1, I=3, L=2, SETTLE_LEN=4), start at t → `busy` t+1..t+21; `done`=1 only at t+22; `pump_valves` at t+7..t+12 = 110,100,101,001,011,010.
- Zero lengths (all cfg=0, R=0) → FILL 1, SETTLE1 4, no MIX, INCUBATE 1, FLUSH 1, SETTLE2 4; `done` at t+12.
- Abort during MIX step 3 at cycle a → all valves 1 from a+1; `aborted` at a+5; `done` never asserts; next start accepted at a+6.
- Start pulsed while busy and cfg changed mid-run → sequence and timing identical to the normal run.
- `rst` asserted during FLUSH → next cycle all valves 1, `busy`=0, `done`=0, state IDLE.
- Start and abort together in IDLE → remains IDLE, no `busy`, no `aborted`.
